gate_bus_pipe: RTL
==================

Name: gate_bus_pipe

Overview:
Next-generation bitwise gate bus with N inputs and an op-code selected at run time instead of at elaboration. Each input has a per-bit inversion mask. The block is a valid/ready pipeline of configurable depth with full throughput and backpressure. It sits between datapath stages that need masked multi-operand logic, replacing fixed-function registered gate buses.

Parameters:
C_WIDTH, 16, bits per operand and result
C_INPUTS, 4, number of operands, 1..8
C_INV_MASK, 0, C_INPUTS*C_WIDTH bit vector; operand k is XORed with slice [k*C_WIDTH +: C_WIDTH] before the gate
C_LATENCY, 2, pipeline stages, 1..4
C_SINIT_VAL, 0, C_WIDTH value loaded into the result registers by SINIT

Ports:
CLK  in  1  clock; all logic is on the rising edge
SCLR  in  1  reset, synchronous, active-high
CE  in  1  clock enable; when 0 the block is frozen
SINIT  in  1  synchronous init: flushes the pipeline and loads C_SINIT_VAL
IN_VALID  in  1  operand beat valid
IN_READY  out  1  block accepts a beat this cycle
I  in  C_INPUTS*C_WIDTH  operands; operand k is I[k*C_WIDTH +: C_WIDTH]
OP  in  3  op code: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 INV, 7 BUF
OUT_VALID  out  1  result beat valid
OUT_READY  in  1  downstream accepts the result
Q  out  C_WIDTH  result
OP_Q  out  3  op code travelling with the result
BUSY  out  1  OR of all stage valid bits

Behaviour:
- Operand conditioning: m_k = operand_k ^ mask_k.
- Ops 0–5: bitwise reduction over m_0..m_{C_INPUTS-1}.
- Ops 6 and 7: use m_0 only; the other operands are ignored.
- C_INPUTS=1: AND/OR/XOR give m_0; NAND/NOR/XNOR give ~m_0.
- Evaluation is combinational into stage 1. Stages 2..C_LATENCY are pure delay slices, each holding valid, data and op.
- Handshakes, all gated by CE:
  - Last stage empties when OUT_VALID & OUT_READY & CE.
  - Stage s loads when CE & (!v_s | stage s empties).
  - IN_READY = CE & (!v_1 | stage 1 advances).
  - A beat is accepted when IN_VALID & IN_READY.
- Throughput: one beat per cycle under continuous OUT_READY.
- Latency: a beat accepted at edge n shows OUT_VALID=1 and its Q after edge n+C_LATENCY-1.
  - With C_LATENCY=1, the result appears right after the accepting edge.
- Backpressure: if OUT_READY=0, Q and OP_Q hold stable while OUT_VALID=1, and stages fill upstream in order. When all stages are valid, IN_READY=0. No beat is ever dropped or duplicated.
- CE=0: every register holds and IN_READY=0. OUT_VALID and Q stay as they were; a held beat is not counted as consumed.
- Same cycle fill and drain at a full pipeline: IN_READY=1 and every stage shifts.
- SCLR (priority over SINIT and CE): all valids 0, Q=0, OP_Q=0, BUSY=0 after the edge. Mid-flight beats are discarded.
- SINIT (ignored when SCLR=1; acts regardless of CE): all valids 0, every stage data = C_SINIT_VAL, OP_Q=7. Q equals C_SINIT_VAL until the next result drains.
- Reset values: IN_READY=1 if CE else 0; OUT_VALID=0; Q=0; OP_Q=0; BUSY=0.
- No X-resolution logic; the block is synthesisable RTL only.

Optional Feature:
GATE_BUS_REDUCE_EN
- Defined: adds output ports RED_AND, RED_OR and RED_XOR, each 1 bit. They hold the unary reductions of the stage-1 result and travel through the pipeline beside Q, with identical valid and hold rules.
  - Reset value 0.
  - SINIT loads the reductions of C_SINIT_VAL.
- Undefined: the ports and registers are absent; all other behaviour is identical.

Decomposition:
- Package gate_bus_pkg:
  - OP code constants GB_AND..GB_BUF.
  - Op-code type width 3.
  - Function gb_eval(op, operands, masks) for combinational evaluation.
- One sub-module, gate_bus_stage: a parametrised valid/data register slice with load/hold/clear/init. It is instantiated C_LATENCY times via generate.

Test Plan:
1. W=8, N=3, mask 0, LAT=2, OP=AND, I={FF,0F,3C}, OUT_READY=1 -> OUT_VALID after 1 extra edge, Q=0C, OP_Q=0; back-to-back OP=XOR same I -> next cycle Q=CC.
2. Mask of operand1=FF, OP=OR, I={00,FF,00} -> Q=00; OP=INV, I0=A5 -> Q=5A; N=1, OP=NAND, I0=F0 -> Q=0F.
3. LAT=3, stream 6 beats with OUT_READY=0 -> IN_READY drops after beat 3. Release OUT_READY -> beats exit in order, one per cycle, none lost.
4. CE=0 for 2 cycles mid-stream with OUT_VALID=1 -> Q, OUT_VALID and stage contents unchanged, IN_READY=0; resume -> sequence intact.
5. SCLR with 2 beats in flight -> next cycle OUT_VALID=0, BUSY=0, Q=00. SINIT with C_SINIT_VAL=5A -> Q=5A, OUT_VALID=0. SCLR and SINIT together -> Q=00.
6. GATE_BUS_REDUCE_EN defined, Q=81 -> RED_AND=0, RED_OR=1, RED_XOR=0 aligned with OUT_VALID.

Source files
------------

// File: rtl/gate_bus_pkg.sv
// Shared op-code type, sizing limits and the masked multi-operand gate evaluator
// for the gate_bus_pipe block.
package gate_bus_pkg;

  localparam int unsigned GB_OP_W       = 3;
  localparam int unsigned GB_MAX_WIDTH  = 64;
  localparam int unsigned GB_MAX_INPUTS = 8;
  localparam int unsigned GB_VEC_W      = GB_MAX_INPUTS * GB_MAX_WIDTH;

  typedef enum logic [GB_OP_W-1:0] {
    GB_AND  = 3'd0,
    GB_NAND = 3'd1,
    GB_OR   = 3'd2,
    GB_NOR  = 3'd3,
    GB_XOR  = 3'd4,
    GB_XNOR = 3'd5,
    GB_INV  = 3'd6,
    GB_BUF  = 3'd7
  } gb_op_t;

  // Operands and masks are packed at GB_MAX_WIDTH pitch; callers take the low result bits.
  function automatic logic [GB_MAX_WIDTH-1:0] gb_eval(
    input gb_op_t                  op,
    input logic [GB_VEC_W-1:0]     operands,
    input logic [GB_VEC_W-1:0]     masks,
    input int unsigned             n_inputs
  );
    logic [GB_MAX_WIDTH-1:0] m;
    logic [GB_MAX_WIDTH-1:0] m0;
    logic [GB_MAX_WIDTH-1:0] acc_and;
    logic [GB_MAX_WIDTH-1:0] acc_or;
    logic [GB_MAX_WIDTH-1:0] acc_xor;
    logic [GB_MAX_WIDTH-1:0] res;
    acc_and = '1;
    acc_or  = '0;
    acc_xor = '0;
    m       = '0;
    res     = '0;
    m0      = operands[GB_MAX_WIDTH-1:0] ^ masks[GB_MAX_WIDTH-1:0];
    for (int unsigned k = 0; k < GB_MAX_INPUTS; k++) begin
      if (k < n_inputs) begin
        m       = operands[k*GB_MAX_WIDTH +: GB_MAX_WIDTH] ^ masks[k*GB_MAX_WIDTH +: GB_MAX_WIDTH];
        acc_and = acc_and & m;
        acc_or  = acc_or | m;
        acc_xor = acc_xor ^ m;
      end
    end
    case (op)
      GB_AND:  res = acc_and;
      GB_NAND: res = ~acc_and;
      GB_OR:   res = acc_or;
      GB_NOR:  res = ~acc_or;
      GB_XOR:  res = acc_xor;
      GB_XNOR: res = ~acc_xor;
      GB_INV:  res = ~m0;
      GB_BUF:  res = m0;
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/gate_bus_pipe_if.sv
// Operand/result handshake bundle for gate_bus_pipe.
// GATE_BUS_REDUCE_EN adds the RED_AND/RED_OR/RED_XOR result side-band.
interface gate_bus_pipe_if
  import gate_bus_pkg::*;
#(
  parameter int unsigned C_WIDTH  = 16,
  parameter int unsigned C_INPUTS = 4
);

  logic                        IN_VALID;
  logic                        IN_READY;
  logic [C_INPUTS*C_WIDTH-1:0] I;
  logic [GB_OP_W-1:0]          OP;
  logic                        OUT_VALID;
  logic                        OUT_READY;
  logic [C_WIDTH-1:0]          Q;
  logic [GB_OP_W-1:0]          OP_Q;
  logic                        BUSY;
`ifdef GATE_BUS_REDUCE_EN
  logic                        RED_AND;
  logic                        RED_OR;
  logic                        RED_XOR;
`endif

  modport slave (
    input  IN_VALID, I, OP, OUT_READY,
    output IN_READY, OUT_VALID, Q, OP_Q, BUSY
`ifdef GATE_BUS_REDUCE_EN
    , output RED_AND, RED_OR, RED_XOR
`endif
  );

  modport master (
    output IN_VALID, I, OP, OUT_READY,
    input  IN_READY, OUT_VALID, Q, OP_Q, BUSY
`ifdef GATE_BUS_REDUCE_EN
    , input RED_AND, RED_OR, RED_XOR
`endif
  );

endinterface

// File: rtl/gate_bus_stage.sv
// One valid/data pipeline slice with load, hold, synchronous clear and init.
module gate_bus_stage #(
  parameter int unsigned     C_DW   = 8,
  parameter logic [C_DW-1:0] C_INIT = '0
) (
  input  logic            CLK,
  input  logic            i_sclr,
  input  logic            i_sinit,
  input  logic            i_load,
  input  logic            i_valid,
  input  logic [C_DW-1:0] i_data,
  output logic            o_valid,
  output logic [C_DW-1:0] o_data
);

  logic            r_valid;
  logic [C_DW-1:0] r_data;

  // Data only moves with a valid beat so a bubble never disturbs the held result.
  always_ff @(posedge CLK) begin
    if (i_sclr) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_sinit) begin
      r_valid <= 1'b0;
      r_data  <= C_INIT;
    end else if (i_load) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/gate_bus_pipe.sv
// Run-time op-code masked gate bus feeding a C_LATENCY-deep valid/ready pipeline.
// GATE_BUS_REDUCE_EN carries AND/OR/XOR reductions of each result beside Q.
module gate_bus_pipe
  import gate_bus_pkg::*;
#(
  parameter int unsigned                 C_WIDTH     = 16,
  parameter int unsigned                 C_INPUTS    = 4,
  parameter logic [C_INPUTS*C_WIDTH-1:0] C_INV_MASK  = '0,
  parameter int unsigned                 C_LATENCY   = 2,
  parameter logic [C_WIDTH-1:0]          C_SINIT_VAL = '0
) (
  input  logic          CLK,
  input  logic          SCLR,
  input  logic          CE,
  input  logic          SINIT,
  gate_bus_pipe_if.slave bus
);

  // Stage word layout (LSB first): result, op code, then the optional reductions.
`ifdef GATE_BUS_REDUCE_EN
  localparam int unsigned    C_DW   = C_WIDTH + GB_OP_W + 3;
  localparam logic [C_DW-1:0] C_INIT = {&C_SINIT_VAL, |C_SINIT_VAL, ^C_SINIT_VAL,
                                        GB_BUF, C_SINIT_VAL};
`else
  localparam int unsigned    C_DW   = C_WIDTH + GB_OP_W;
  localparam logic [C_DW-1:0] C_INIT = {GB_BUF, C_SINIT_VAL};
`endif

  logic [GB_VEC_W-1:0]  w_ops;
  logic [GB_VEC_W-1:0]  w_msk;
  logic [C_WIDTH-1:0]   w_res;
  logic [C_DW-1:0]      w_in;
  logic                 w_drain;
  logic                 w_nxt;
  logic [C_LATENCY-1:0] w_valid;
  logic [C_LATENCY-1:0] w_load;
  logic [C_DW-1:0]      w_data [C_LATENCY];

  // Re-pack operands and masks to the evaluator's fixed pitch.
  always_comb begin
    w_ops = '0;
    w_msk = '0;
    for (int unsigned k = 0; k < C_INPUTS; k++) begin
      w_ops[k*GB_MAX_WIDTH +: C_WIDTH] = bus.I[k*C_WIDTH +: C_WIDTH];
      w_msk[k*GB_MAX_WIDTH +: C_WIDTH] = C_INV_MASK[k*C_WIDTH +: C_WIDTH];
    end
  end

  assign w_res = C_WIDTH'(gb_eval(gb_op_t'(bus.OP), w_ops, w_msk, C_INPUTS));

`ifdef GATE_BUS_REDUCE_EN
  assign w_in = {&w_res, |w_res, ^w_res, bus.OP, w_res};
`else
  assign w_in = {bus.OP, w_res};
`endif

  assign w_drain = CE & w_valid[C_LATENCY-1] & bus.OUT_READY;

  // A stage loads when empty or when its successor takes its beat; walk from the output back.
  always_comb begin
    w_load = '0;
    w_nxt  = w_drain;
    for (int s = int'(C_LATENCY) - 1; s >= 0; s--) begin
      w_nxt     = CE & (~w_valid[s] | w_nxt);
      w_load[s] = w_nxt;
    end
  end

  for (genvar s = 0; s < int'(C_LATENCY); s++) begin : g_stage
    logic            w_vin;
    logic [C_DW-1:0] w_din;

    if (s == 0) begin : g_head
      assign w_vin = bus.IN_VALID;
      assign w_din = w_in;
    end else begin : g_body
      assign w_vin = w_valid[s-1];
      assign w_din = w_data[s-1];
    end

    gate_bus_stage #(
      .C_DW   (C_DW),
      .C_INIT (C_INIT)
    ) u_stage (
      .CLK     (CLK),
      .i_sclr  (SCLR),
      .i_sinit (SINIT),
      .i_load  (w_load[s]),
      .i_valid (w_vin),
      .i_data  (w_din),
      .o_valid (w_valid[s]),
      .o_data  (w_data[s])
    );
  end

  assign bus.IN_READY  = w_load[0];
  assign bus.OUT_VALID = w_valid[C_LATENCY-1];
  assign bus.Q         = w_data[C_LATENCY-1][C_WIDTH-1:0];
  assign bus.OP_Q      = w_data[C_LATENCY-1][C_WIDTH +: GB_OP_W];
  assign bus.BUSY      = |w_valid;

`ifdef GATE_BUS_REDUCE_EN
  assign bus.RED_AND = w_data[C_LATENCY-1][C_DW-1];
  assign bus.RED_OR  = w_data[C_LATENCY-1][C_DW-2];
  assign bus.RED_XOR = w_data[C_LATENCY-1][C_DW-3];
`endif

endmodule
